// File: rtl/demux_unit.sv
// Two-lane demux: each lane stages one beat, then writes it into one of four banks. Lane 0 wins bank conflicts. Optional DEMUX_CONST_CHECK_EN adds a constant check on drains.
// Latency: 2 cycles from input presentation to bank output, plus 1 cycle for each cycle lane 1 is blocked.
// Backpressure: ready = stage empty or draining this cycle, so ready_0 is always 1. ready_1 drops only while lane 1 is blocked by lane 0.
module demux_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] sel_0,
    input  logic [1:0] sel_1,
    input  logic [7:0] in_0,
    input  logic [7:0] in_1,
    input  logic       valid_0,
    input  logic       valid_1,
    output logic       ready_0,
    output logic       ready_1,
    output logic [7:0] bank_0,
    output logic [7:0] bank_1,
    output logic [7:0] bank_2,
    output logic [7:0] bank_3,
    output logic [3:0] filled,
    output logic [7:0] conflicts,
    output logic       mismatch
);

    logic       r_stg_full_0;
    logic       r_stg_full_1;
    logic [1:0] r_stg_sel_0;
    logic [1:0] r_stg_sel_1;
    logic [7:0] r_stg_data_0;
    logic [7:0] r_stg_data_1;
    logic [7:0] r_bank [4];
    logic [3:0] r_filled;
    logic [7:0] r_conflicts;

    logic w_blocked_1;
    logic w_drain_0;
    logic w_drain_1;
    logic w_hs_0;
    logic w_hs_1;

    assign w_blocked_1 = r_stg_full_0 && r_stg_full_1 && (r_stg_sel_0 == r_stg_sel_1);
    assign w_drain_0   = r_stg_full_0;
    assign w_drain_1   = r_stg_full_1 && !w_blocked_1;

    assign ready_0 = !r_stg_full_0 || w_drain_0;
    assign ready_1 = !r_stg_full_1 || w_drain_1;

    // Reset outranks a handshake presented in the same cycle.
    assign w_hs_0 = valid_0 && ready_0 && !rst;
    assign w_hs_1 = valid_1 && ready_1 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_full_0 <= 1'b0;
            r_stg_sel_0  <= 2'd0;
            r_stg_data_0 <= 8'd0;
        end else if (w_hs_0) begin
            r_stg_full_0 <= 1'b1;
            r_stg_sel_0  <= sel_0;
            r_stg_data_0 <= in_0;
        end else if (w_drain_0) begin
            r_stg_full_0 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stg_full_1 <= 1'b0;
            r_stg_sel_1  <= 2'd0;
            r_stg_data_1 <= 8'd0;
        end else if (w_hs_1) begin
            r_stg_full_1 <= 1'b1;
            r_stg_sel_1  <= sel_1;
            r_stg_data_1 <= in_1;
        end else if (w_drain_1) begin
            r_stg_full_1 <= 1'b0;
        end
    end

    // Both lanes never drain into the same bank in one cycle. A drain in a clear cycle overrides the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) r_bank[k] <= 8'd0;
            r_filled <= 4'd0;
        end else begin
            if (clear) begin
                for (int k = 0; k < 4; k++) r_bank[k] <= 8'd0;
                r_filled <= 4'd0;
            end
            if (w_drain_0) begin
                r_bank[r_stg_sel_0]   <= r_stg_data_0;
                r_filled[r_stg_sel_0] <= 1'b1;
            end
            if (w_drain_1) begin
                r_bank[r_stg_sel_1]   <= r_stg_data_1;
                r_filled[r_stg_sel_1] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_conflicts <= 8'd0;
        end else if (w_blocked_1 && (r_conflicts != 8'hFF)) begin
            r_conflicts <= r_conflicts + 8'd1;
        end
    end

`ifdef DEMUX_CONST_CHECK_EN
    logic w_bad_0;
    logic w_bad_1;
    logic r_mismatch;

    // Lane 0 expects the bank number in the data. Lane 1 expects the bank number plus 3. Bank 0 is not checked.
    assign w_bad_0 = w_drain_0 && (r_stg_sel_0 != 2'd0) && (r_stg_data_0 != {6'd0, r_stg_sel_0});
    assign w_bad_1 = w_drain_1 && (r_stg_sel_1 != 2'd0) && (r_stg_data_1 != ({6'd0, r_stg_sel_1} + 8'd3));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else if (w_bad_0 || w_bad_1) begin
            r_mismatch <= 1'b1;
        end else if (clear) begin
            r_mismatch <= 1'b0;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

    assign bank_0    = r_bank[0];
    assign bank_1    = r_bank[1];
    assign bank_2    = r_bank[2];
    assign bank_3    = r_bank[3];
    assign filled    = r_filled;
    assign conflicts = r_conflicts;

endmodule

// File: tb/tb_demux_unit.sv
// Bench for demux_unit: directed scenarios plus randomized traffic.
// Each step is checked against a transaction-level model of lanes and banks.
module tb_demux_unit;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [1:0] sel_0;
    logic [1:0] sel_1;
    logic [7:0] in_0;
    logic [7:0] in_1;
    logic       valid_0;
    logic       valid_1;
    logic       ready_0;
    logic       ready_1;
    logic [7:0] bank_0;
    logic [7:0] bank_1;
    logic [7:0] bank_2;
    logic [7:0] bank_3;
    logic [3:0] filled;
    logic [7:0] conflicts;
    logic       mismatch;

    int n_cmp  = 0;
    int n_fail = 0;

    demux_unit dut (
        .clk(clk), .rst(rst), .clear(clear),
        .sel_0(sel_0), .sel_1(sel_1), .in_0(in_0), .in_1(in_1),
        .valid_0(valid_0), .valid_1(valid_1),
        .ready_0(ready_0), .ready_1(ready_1),
        .bank_0(bank_0), .bank_1(bank_1), .bank_2(bank_2), .bank_3(bank_3),
        .filled(filled), .conflicts(conflicts), .mismatch(mismatch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef DEMUX_CONST_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    // Reference model: a pending beat per lane plus bank contents and counters.
    bit         m_pend [2];
    logic [1:0] m_dst  [2];
    logic [7:0] m_val  [2];
    logic [7:0] m_bank [4];
    logic [3:0] m_filled;
    int         m_conf;
    bit         m_mm;

    function automatic bit m_lane1_blocked();
        return m_pend[0] && m_pend[1] && (m_dst[0] == m_dst[1]);
    endfunction

    function automatic bit m_ready(int lane);
        if (!m_pend[lane]) return 1'b1;
        return (lane == 0) ? 1'b1 : !m_lane1_blocked();
    endfunction

    function automatic logic [46:0] m_vec();
        return {m_bank[0], m_bank[1], m_bank[2], m_bank[3], m_filled, 8'(m_conf), m_mm,
                m_ready(0), m_ready(1)};
    endfunction

    function automatic logic [46:0] dut_vec();
        return {bank_0, bank_1, bank_2, bank_3, filled, conflicts, mismatch, ready_0, ready_1};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_bank[k] = 8'd0;
        for (int l = 0; l < 2; l++) begin
            m_pend[l] = 1'b0;
            m_dst[l]  = 2'd0;
            m_val[l]  = 8'd0;
        end
        m_filled = 4'd0;
        m_conf   = 0;
        m_mm     = 1'b0;
    endtask

    // One clock edge: the DUT updates, and the model applies the same transaction rules.
    task automatic tick();
        bit blk, wr0, wr1, acc0, acc1;
        @(posedge clk);
        blk  = m_lane1_blocked();
        wr0  = m_pend[0];
        wr1  = m_pend[1] && !blk;
        acc0 = valid_0 && m_ready(0) && !rst;
        acc1 = valid_1 && m_ready(1) && !rst;
        if (rst) begin
            model_reset();
        end else begin
            if (clear) begin
                for (int k = 0; k < 4; k++) m_bank[k] = 8'd0;
                m_filled = 4'd0;
                m_conf   = 0;
                m_mm     = 1'b0;
            end else if (blk && m_conf < 255) begin
                m_conf++;
            end
            if (wr0) begin
                m_bank[m_dst[0]] = m_val[0];
                m_filled[m_dst[0]] = 1'b1;
                if (CHECK_EN && m_dst[0] != 0 && int'(m_val[0]) != int'(m_dst[0])) m_mm = 1'b1;
            end
            if (wr1) begin
                m_bank[m_dst[1]] = m_val[1];
                m_filled[m_dst[1]] = 1'b1;
                if (CHECK_EN && m_dst[1] != 0 && int'(m_val[1]) != int'(m_dst[1]) + 3) m_mm = 1'b1;
            end
            if (acc0) begin m_pend[0] = 1'b1; m_dst[0] = sel_0; m_val[0] = in_0; end
            else if (wr0) m_pend[0] = 1'b0;
            if (acc1) begin m_pend[1] = 1'b1; m_dst[1] = sel_1; m_val[1] = in_1; end
            else if (wr1) m_pend[1] = 1'b0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
        sel_0 = 2'd0; sel_1 = 2'd0; in_0 = 8'd0; in_1 = 8'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; valid_0 = 1'b1; valid_1 = 1'b1; in_0 = 8'h3C; in_1 = 8'hC3;
        tick();
        tick();
        n_cmp++;
        if ({ready_0, ready_1} !== 2'b11) begin
            n_fail++; $display("FAIL reset_ready_during_rst: got %b want 11", {ready_0, ready_1});
        end
        rst = 1'b0; idle_inputs();
        n_cmp++;
        if (dut_vec() !== {32'd0, 4'd0, 8'd0, 1'b0, 2'b11}) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", dut_vec(), {32'd0, 4'd0, 8'd0, 1'b0, 2'b11});
        end
        tick();
        n_cmp++;
        if (filled !== 4'd0 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL reset_hs_ignored: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_basic();
        valid_0 = 1'b1; sel_0 = 2'd0; in_0 = 8'hA5;
        tick();
        idle_inputs();
        n_cmp++;
        if (bank_0 !== 8'h00) begin
            n_fail++; $display("FAIL basic_not_early: got %h want 00", bank_0);
        end
        tick();
        n_cmp++;
        if (bank_0 !== 8'hA5 || filled !== 4'b0001 || conflicts !== 8'd0 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL basic_write: got %h want bank_0=a5 filled=1 (model %h)", dut_vec(), m_vec());
        end
    endtask

    task automatic test_parallel();
        valid_0 = 1'b1; sel_0 = 2'd2; in_0 = 8'h02;
        valid_1 = 1'b1; sel_1 = 2'd3; in_1 = 8'h06;
        n_cmp++;
        if ({ready_0, ready_1} !== 2'b11) begin
            n_fail++; $display("FAIL parallel_ready_pre: got %b want 11", {ready_0, ready_1});
        end
        tick();
        idle_inputs();
        n_cmp++;
        if ({ready_0, ready_1} !== 2'b11) begin
            n_fail++; $display("FAIL parallel_ready_mid: got %b want 11", {ready_0, ready_1});
        end
        tick();
        n_cmp++;
        if (bank_2 !== 8'h02 || bank_3 !== 8'h06 || mismatch !== 1'b0 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL parallel_write: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_conflict();
        valid_0 = 1'b1; sel_0 = 2'd1; in_0 = 8'h11;
        valid_1 = 1'b1; sel_1 = 2'd1; in_1 = 8'h22;
        tick();
        idle_inputs();
        n_cmp++;
        if ({ready_0, ready_1} !== 2'b10) begin
            n_fail++; $display("FAIL conflict_ready_blocked: got %b want 10", {ready_0, ready_1});
        end
        tick();
        n_cmp++;
        if (bank_1 !== 8'h11 || ready_1 !== 1'b1 || conflicts !== 8'd1) begin
            n_fail++; $display("FAIL conflict_first: got bank_1=%h ready_1=%b conflicts=%0d want 11/1/1", bank_1, ready_1, conflicts);
        end
        tick();
        n_cmp++;
        if (bank_1 !== 8'h22 || conflicts !== 8'd1 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL conflict_second: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_saturation_clear();
        valid_0 = 1'b1; valid_1 = 1'b1; sel_0 = 2'd0; sel_1 = 2'd0;
        for (int i = 0; i < 300; i++) begin
            in_0 = 8'($urandom); in_1 = 8'($urandom);
            tick();
        end
        n_cmp++;
        if (conflicts !== 8'd255 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL sat_count: got conflicts=%0d want 255 (vec %h want %h)", conflicts, dut_vec(), m_vec());
        end
        clear = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (conflicts !== 8'd0 || filled !== 4'b0001 || {bank_1, bank_2, bank_3} !== 24'd0
            || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL sat_clear: got %h want %h", dut_vec(), m_vec());
        end
        tick(); tick(); tick();
        n_cmp++;
        if (dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL sat_drain: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_const_check();
        clear = 1'b1;
        tick();
        idle_inputs();
        valid_0 = 1'b1; sel_0 = 2'd1; in_0 = 8'h01;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (mismatch !== 1'b0) begin
            n_fail++; $display("FAIL const_good_value: got %b want 0", mismatch);
        end
        valid_1 = 1'b1; sel_1 = 2'd2; in_1 = 8'h07;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        n_cmp++;
        if (mismatch !== CHECK_EN || bank_2 !== 8'h07 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL const_bad_value: got mismatch=%b bank_2=%h want %b/07", mismatch, bank_2, CHECK_EN);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_cmp++;
        if (mismatch !== 1'b0 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL const_clear: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_reset_midflight();
        valid_0 = 1'b1; sel_0 = 2'd3; in_0 = 8'($urandom_range(1, 255));
        valid_1 = 1'b1; sel_1 = 2'd1; in_1 = 8'h04;
        tick();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (dut_vec() !== {32'd0, 4'd0, 8'd0, 1'b0, 2'b11}) begin
            n_fail++; $display("FAIL midflight_reset: got %h want %h", dut_vec(), {32'd0, 4'd0, 8'd0, 1'b0, 2'b11});
        end
        tick(); tick();
        n_cmp++;
        if (bank_3 !== 8'd0 || filled !== 4'd0 || dut_vec() !== m_vec()) begin
            n_fail++; $display("FAIL midflight_discard: got %h want %h", dut_vec(), m_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 299) == 0);
            clear   = ($urandom_range(0, 39) == 0);
            valid_0 = 1'($urandom_range(0, 1));
            valid_1 = ($urandom_range(0, 3) != 0);
            sel_0   = 2'($urandom);
            sel_1   = 2'($urandom);
            in_0    = ($urandom_range(0, 1) == 0) ? 8'({30'd0, sel_0}) : 8'($urandom);
            in_1    = ($urandom_range(0, 1) == 0) ? 8'({30'd0, sel_1} + 3) : 8'($urandom);
            n_cmp++;
            if ({ready_0, ready_1} !== {m_ready(0), m_ready(1)}) begin
                n_fail++;
                if (bad++ < 10) $display("FAIL random_ready @%0d: got %b want %b", i, {ready_0, ready_1}, {m_ready(0), m_ready(1)});
            end
            tick();
            n_cmp++;
            if (dut_vec() !== m_vec()) begin
                n_fail++;
                if (bad++ < 10) $display("FAIL random_state @%0d: got %h want %h", i, dut_vec(), m_vec());
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_parallel();
        test_conflict();
        test_saturation_clear();
        test_const_check();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_unit.md
# demux_unit

Two-lane registered demultiplexer that performs the inverse of the select-driven byte mux stage. Each lane accepts an 8-bit value and a 2-bit destination select over a valid/ready handshake, buffers it in a one-entry stage register, and writes it into one of four shared 8-bit bank registers. Lane 0 has fixed priority on bank-write conflicts. The block sits downstream of the mux stage in the timing-tutorial datapath and collects its results for inspection.

## Interface
- No parameters. Data width is fixed at 8 bits and bank count is fixed at 4.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of the banks, `filled`, `conflicts` and `mismatch`
- sel_0, sel_1  in  2 each  destination bank for lane 0 / lane 1
- in_0, in_1  in  8 each  data for lane 0 / lane 1
- valid_0, valid_1  in  1 each  lane has a beat to offer
- ready_0, ready_1  out  1 each  lane can accept a beat this cycle
- bank_0, bank_1, bank_2, bank_3  out  8 each  bank register contents
- filled  out  4  bit k set when bank k has been written since the last rst or clear
- conflicts  out  8  saturating count of cycles in which lane 1 was blocked by lane 0
- mismatch  out  1  sticky constant-check failure; see Configuration

## Operation
- Each lane has one stage entry: `stg_full`, `stg_sel[1:0]` and `stg_data[7:0]`.
- A handshake occurs when valid and ready are both high at a rising edge. The stage entry loads `sel` and `in`, and `stg_full` is set to 1.
- A lane drains when its stage is full and it is granted the write:
  - Lane 0 is always granted.
  - Lane 1 is granted unless lane 0 is also full with the same `stg_sel`.
- On drain, `bank[stg_sel]` takes `stg_data` and `filled[stg_sel]` is set to 1.
- Two full stages with different selects both write in the same cycle.
- `ready_n = !stg_full_n || drain_n`. The same stage can drain and reload in one cycle, which gives full throughput.
- A blocked lane 1 holds its stage entry and drives `ready_1 = 0`. It retries every cycle.
- `conflicts` increments on every blocked cycle and saturates at 255.
- `clear` behaviour:
  - Zeroes the banks, `filled`, `conflicts` and `mismatch`.
  - Does not affect the stage entries or handshakes.
  - A drain in the same cycle as `clear` still writes: that bank takes the data and its `filled` bit is set.
  - When `clear` and a conflict occur in the same cycle, `conflicts` ends at 0.
- `rst` behaviour:
  - Clears everything, including the stage entries.
  - An in-flight beat is discarded.
  - A handshake presented in the reset cycle is not accepted.

## Timing
- Reset values:
  - `bank_0`..`bank_3` = 0x00, `filled` = 0, `conflicts` = 0, `mismatch` = 0.
  - `ready_0` = `ready_1` = 1 in the first cycle after reset deasserts. `ready` is combinational from stage state and is 1 during reset as well, but no handshake is accepted in the reset cycle.
- Latency with no conflict:
  - Handshake at edge E0 loads the stage.
  - The bank is written at edge E0+1, and the value is visible on `bank_k` after E0+1.
  - Total latency is 2 cycles from the input presentation to the bank output.
- Each conflict adds one cycle of latency for lane 1.
- Sustained throughput is one beat per cycle per lane when the two lanes target different banks.
- All outputs other than `ready_0`/`ready_1` are registered.

## Configuration
- Macro: `DEMUX_CONST_CHECK_EN`.
- When defined, each drain to bank 1, 2 or 3 is compared against an expected constant:
  - lane 0 expects 0x01, 0x02, 0x03 for banks 1, 2, 3
  - lane 1 expects 0x04, 0x05, 0x06 for banks 1, 2, 3
  - drains to bank 0 are never checked
- Any inequality sets `mismatch` at the same edge as the write. `mismatch` stays set until `rst` or `clear`.
- When not defined, `mismatch` is tied to 0 and no compare logic is synthesised.
- All other behaviour is identical with and without the macro.

## Test plan
- **Basic write:** after reset, lane 0 sends `sel`=0, `in`=0xA5 -> `bank_0` = 0xA5 and `filled` = 4'b0001 two cycles after presentation; `conflicts` = 0.
- **Parallel writes:** both lanes valid in the same cycle, lane 0 `sel`=2 / 0x02, lane 1 `sel`=3 / 0x06 -> both banks written on the same edge; `ready_0` = `ready_1` = 1 throughout; `mismatch` = 0 with the macro defined.
- **Conflict:** both lanes `sel`=1, data 0x11 and 0x22 -> `bank_1` = 0x11 after the first write edge and 0x22 one cycle later; `ready_1` = 0 for exactly one cycle; `conflicts` = 1.
- **Saturation and clear:** hold both lanes on `sel`=0 with valid high for 300 cycles -> `conflicts` stops at 255; pulse `clear` -> `conflicts` = 0, `filled` = 0 and the banks read 0x00, except a bank written on the clear edge.
- **Constant check (macro defined):** lane 1 writes 0x07 to bank 2 -> `mismatch` = 1 and stays high until `clear`; the same sequence without the macro -> `mismatch` = 0.
- **Reset mid-flight:** handshake a beat, assert `rst` on the next edge -> no bank is written, all outputs return to their reset values, and `ready` = 1 after reset deasserts.
